// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, LSB first, with a one-word holding register.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-2:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               dout_last_q, dout_last_d;
`ifdef PISO_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  logic               xfer;
  logic               free;
  logic               load;
  logic [WIDTH-1:0]   load_word;

  always_comb begin
    xfer      = din_valid && !hold_full_q;
`ifdef PISO_TX_PARITY_EN
    free      = (state_q == IDLE) || (state_q == PARITY);
`else
    free      = (state_q == IDLE) ||
                ((state_q == SHIFT) && (cnt_q == CW'(WIDTH-1)));
`endif
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    load_word   = din;

    // A pending held word always wins over a direct load from din.
    if (free && hold_full_q) begin
      load        = 1'b1;
      load_word   = hold_q;
      hold_full_d = 1'b0;
    end else if (free && xfer) begin
      load        = 1'b1;
    end else if (!free && xfer) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    dout_last_d  = 1'b0;
`ifdef PISO_TX_PARITY_EN
    par_d        = par_q;
`endif

    if (load) begin
      state_d      = SHIFT;
      cnt_d        = '0;
      dout_d       = load_word[0];
      shreg_d      = load_word[WIDTH-1:1];
      dout_valid_d = 1'b1;
`ifdef PISO_TX_PARITY_EN
      par_d        = ^load_word;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q == CW'(WIDTH-1)) begin
`ifdef PISO_TX_PARITY_EN
            state_d      = PARITY;
            dout_d       = par_q;
            dout_valid_d = 1'b1;
            dout_last_d  = 1'b1;
`else
            state_d      = IDLE;
`endif
          end else begin
            cnt_d        = cnt_q + 1'b1;
            dout_d       = shreg_q[0];
            shreg_d      = shreg_q >> 1;
            dout_valid_d = 1'b1;
`ifndef PISO_TX_PARITY_EN
            dout_last_d  = (cnt_q == CW'(WIDTH-2));
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
`ifdef PISO_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign din_ready  = !hold_full_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign busy       = (state_q != IDLE) || hold_full_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx (WIDTH=4): queue-based frame model checked every cycle plus literal vectors.
module tb_piso_tx;
  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready, dout, dout_valid, dout_last, busy;

  int checks = 0;
  int errors = 0;

  piso_tx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bits still to appear on the line for the current frame, plus one held word.
  logic   mq[$];
  logic   mh_full = 1'b0;
  logic [W-1:0] mh_word;
  logic   started = 1'b0;
  logic   stream[$];

  task automatic push_frame(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) mq.push_back(w[i]);
`ifdef PISO_TX_PARITY_EN
    mq.push_back(^w);
`endif
  endtask

  always @(posedge clk) begin
    logic m_free, m_xfer;
    if (rst) begin
      mq.delete();
      mh_full = 1'b0;
      started = 1'b1;
    end else if (started) begin
      m_free = (mq.size() <= 1);
      m_xfer = din_valid && !mh_full;
      if (mq.size() > 0) void'(mq.pop_front());
      if (m_free && mh_full) begin
        push_frame(mh_word);
        mh_full = 1'b0;
      end else if (m_free && m_xfer) begin
        push_frame(din);
      end else if (m_xfer) begin
        mh_word = din;
        mh_full = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("dout_valid", dout_valid, mq.size() > 0);
      check("dout", dout, (mq.size() > 0) ? mq[0] : 1'b0);
      check("dout_last", dout_last, mq.size() == 1);
      check("busy", busy, (mq.size() > 0) || mh_full);
      check("din_ready", din_ready, !mh_full);
      if (dout_valid === 1'b1) stream.push_back(dout);
    end
  end

  task automatic send(input logic [W-1:0] w);
    logic rdy;
    din = w;
    din_valid = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      rdy = din_ready;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) return;
    end
    check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string name, input logic [15:0] exp, input int n);
    check({name, "_len"}, stream.size(), n);
    for (int i = 0; i < n && i < stream.size(); i++)
      check(name, stream[i], exp[i]);
    stream.delete();
  endtask

  initial begin
    logic [W-1:0] w1;
    logic [4:0]   e1;
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w1;
    logic [4:0]   e1;
`ifdef PISO_TX_PARITY_EN
    w1 = 4'b0111; e1 = 5'b10111;
`else
    w1 = 4'b1011; e1 = 5'b01011;
`endif
    // Reset with din_valid high and din=F: nothing may be accepted.
    rst = 1'b1; din_valid = 1'b1; din = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    check("rst_din_ready", din_ready, 1'b1);
    check("rst_idle_busy", busy, 1'b0);
    drain(2);
    stream.delete();

    // Single word: literal per-cycle bits and last marker.
    send(w1);
    din_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      check("single_bit", dout, e1[k]);
      check("single_valid", dout_valid, 1'b1);
      check("single_last", dout_last, k == NB - 1);
    end
    @(negedge clk);
    check("single_end_valid", dout_valid, 1'b0);
    check("single_end_dout", dout, 1'b0);
    drain(4);
    stream.delete();

    // Back-to-back A then 5.
    send(4'hA);
    send(4'h5);
    din_valid = 1'b0;
    @(negedge clk);
    check("b2b_ready_low", din_ready, 1'b0);
    drain(14);
`ifdef PISO_TX_PARITY_EN
    check_stream("b2b_stream", 16'b0010101010, 10);
`else
    check_stream("b2b_stream", 16'b01011010, 8);
`endif

    // Three words: third stalls until hold drains.
    send(4'h9);
    send(4'h6);
    din = 4'hE;
    @(negedge clk);
    check("three_ready_low", din_ready, 1'b0);
    send(4'hE);
    drain(20);
`ifdef PISO_TX_PARITY_EN
    check_stream("three_stream", 16'b111100011001001, 15);
`else
    check_stream("three_stream", 16'b111001101001, 12);
`endif

    // Reset during bit 2 of C with 3 held.
    send(4'hC);
    send(4'h3);
    din_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_dout", dout, 1'b0);
    check("abort_valid", dout_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    drain(12);
    check_stream("abort_stream", 16'b100, 3);

`ifdef PISO_TX_PARITY_EN
    send(4'b0101);
    drain(10);
    check_stream("parity0_stream", 16'b00101, 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
